// File: rtl/alu_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit_pkg
// Description : ALU operation codes and helpers shared by the execute stage.
// Revision    : 1.0
// ============================================================================
package alu_exec_unit_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] c_alu_none = 4'd0;
    localparam logic [ALU_OP_W-1:0] c_alu_add  = 4'd1;
    localparam logic [ALU_OP_W-1:0] c_alu_sub  = 4'd2;
    localparam logic [ALU_OP_W-1:0] c_alu_and  = 4'd3;
    localparam logic [ALU_OP_W-1:0] c_alu_or   = 4'd4;
    localparam logic [ALU_OP_W-1:0] c_alu_xor  = 4'd5;
    localparam logic [ALU_OP_W-1:0] c_alu_sll  = 4'd6;
    localparam logic [ALU_OP_W-1:0] c_alu_srl  = 4'd7;
    localparam logic [ALU_OP_W-1:0] c_alu_beq  = 4'd8;
    localparam logic [ALU_OP_W-1:0] c_alu_bne  = 4'd9;
    localparam logic [ALU_OP_W-1:0] c_alu_blt  = 4'd10;
    localparam logic [ALU_OP_W-1:0] c_alu_bge  = 4'd11;

    function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
        return (op == c_alu_sll) || (op == c_alu_srl);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_comb_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb_core
// Description : Single-cycle arithmetic, logic and branch-compare datapath.
// Revision    : 1.0
// ============================================================================
module alu_comb_core
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [ALU_OP_W-1:0]   i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_bcond
);

    always_comb begin
        o_result = '0;
        o_bcond  = 1'b0;
        case (i_op)
            c_alu_add: o_result = i_a + i_b;
            c_alu_sub: o_result = i_a - i_b;
            c_alu_and: o_result = i_a & i_b;
            c_alu_or:  o_result = i_a | i_b;
            c_alu_xor: o_result = i_a ^ i_b;
            c_alu_beq: o_bcond  = (i_a == i_b);
            c_alu_bne: o_bcond  = (i_a != i_b);
            c_alu_blt: o_bcond  = ($signed(i_a) <  $signed(i_b));
            c_alu_bge: o_bcond  = ($signed(i_a) >= $signed(i_b));
            // Shifts are handled iteratively by the parent; unknown codes yield zero.
            default: begin
                o_result = '0;
                o_bcond  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage ALU with valid/ready handshakes and a bit-serial shifter.
// Revision    : 1.0
// ============================================================================
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_OP_W-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_bcond
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ALU_OP_W-1:0]   r_op;
    logic [ALU_OP_W-1:0]   w_op_nxt;
    logic [DATA_WIDTH-1:0] r_work;
    logic [DATA_WIDTH-1:0] w_work_nxt;
    logic [SH_W-1:0]       r_cnt;
    logic [SH_W-1:0]       w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_result;
    logic [DATA_WIDTH-1:0] w_result_nxt;
    logic                  r_bcond;
    logic                  w_bcond_nxt;

    logic [DATA_WIDTH-1:0] w_core_result;
    logic                  w_core_bcond;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [SH_W-1:0]       w_shamt;

    alu_comb_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .i_op     (alu_op),
        .i_a      (in_a),
        .i_b      (in_b),
        .o_result (w_core_result),
        .o_bcond  (w_core_bcond)
    );

    assign w_shamt    = in_b[SH_W-1:0];
    assign w_shifted  = (r_op == c_alu_srl) ? (r_work >> 1) : (r_work << 1);
    assign in_ready   = (r_state == c_st_idle);
    assign out_valid  = (r_state == c_st_done);
    assign out_result = r_result;
    assign out_bcond  = r_bcond;

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_work_nxt   = r_work;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_bcond_nxt  = r_bcond;
        case (r_state)
            c_st_idle: begin
                if (in_valid) begin
                    w_op_nxt = alu_op;
                    if (is_shift_op(alu_op)) begin
                        if (w_shamt == '0) begin
                            w_result_nxt = in_a;
                            w_bcond_nxt  = 1'b0;
                            w_state_nxt  = c_st_done;
                        end else begin
                            w_work_nxt  = in_a;
                            w_cnt_nxt   = w_shamt;
                            w_state_nxt = c_st_shift;
                        end
                    end else begin
                        w_result_nxt = w_core_result;
                        w_bcond_nxt  = w_core_bcond;
                        w_state_nxt  = c_st_done;
                    end
                end
            end
            c_st_shift: begin
                w_work_nxt = w_shifted;
                w_cnt_nxt  = r_cnt - SH_W'(1);
                // Last step: publish the value being shifted in this same update.
                if (r_cnt == SH_W'(1)) begin
                    w_result_nxt = w_shifted;
                    w_bcond_nxt  = 1'b0;
                    w_state_nxt  = c_st_done;
                end
            end
            c_st_done: begin
                if (out_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= c_alu_none;
            r_work   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_bcond  <= 1'b0;
        end else begin
            r_op     <= w_op_nxt;
            r_work   <= w_work_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_bcond  <= w_bcond_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit against a behavioural model.
// Revision    : 1.0
// ============================================================================
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    alu_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_bcond;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_bcond  (out_bcond)
    );

    always #5 clk = ~clk;

    // Reference behaviour: {bcond, result}
    function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            c_alu_add: return {1'b0, a + b};
            c_alu_sub: return {1'b0, a - b};
            c_alu_and: return {1'b0, a & b};
            c_alu_or:  return {1'b0, a | b};
            c_alu_xor: return {1'b0, a ^ b};
            c_alu_sll: return {1'b0, a << sh};
            c_alu_srl: return {1'b0, a >> sh};
            c_alu_beq: return {a == b, {W{1'b0}}};
            c_alu_bne: return {a != b, {W{1'b0}}};
            c_alu_blt: return {$signed(a) <  $signed(b), {W{1'b0}}};
            c_alu_bge: return {$signed(a) >= $signed(b), {W{1'b0}}};
            default:   return '0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [W-1:0] b);
        if (op == c_alu_sll || op == c_alu_srl) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for out_valid (bounded), report observations; optionally complete handshake.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit finish_hs,
                          output logic [W-1:0] res, output logic bc, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        alu_op   = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = out_result;
        bc  = out_bcond;
        if (finish_hs && out_valid) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== '0 || out_bcond !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b result=%h bcond=%b required 0 1 0 0",
                     out_valid, in_ready, out_result, out_bcond);
        end
    endtask

    task automatic test_directed();
        logic [3:0]   ops [9];
        logic [W-1:0] as  [9];
        logic [W-1:0] bs  [9];
        logic [W-1:0] res;
        logic         bc;
        int           lat;
        logic [W:0]   exp;
        ops = '{c_alu_add, c_alu_sub, c_alu_blt, c_alu_bge, c_alu_beq, c_alu_sll, c_alu_srl, c_alu_none, 4'd14};
        as  = '{32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd1, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
        bs  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd31, 32'h24, 32'h9ABC_DEF0, 32'h1111_1111};
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b1, res, bc, lat);
            exp = ref_alu(ops[i], as[i], bs[i]);
            checks++;
            if (res !== exp[W-1:0] || bc !== exp[W] || lat != ref_lat(ops[i], bs[i])) begin
                errors++;
                $display("FAIL directed_%0d op=%0d: result=%h bcond=%b lat=%0d required %h %b %0d",
                         i, ops[i], res, bc, lat, exp[W-1:0], exp[W], ref_lat(ops[i], bs[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]   op;
        logic [W-1:0] a, b, res;
        logic         bc;
        int           lat;
        logic [W:0]   exp;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 0) b = a;
            run_op(op, a, b, 1'b1, res, bc, lat);
            exp = ref_alu(op, a, b);
            checks++;
            if (res !== exp[W-1:0] || bc !== exp[W] || lat != ref_lat(op, b)) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: result=%h bcond=%b lat=%0d required %h %b %0d",
                         i, op, a, b, res, bc, lat, exp[W-1:0], exp[W], ref_lat(op, b));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] res;
        logic         bc;
        int           lat;
        run_op(c_alu_bne, 32'd7, 32'd9, 1'b0, res, bc, lat);
        checks++;
        if (res !== '0 || bc !== 1'b1 || lat != 1) begin
            errors++;
            $display("FAIL bp_first: result=%h bcond=%b lat=%0d required 0 1 1", res, bc, lat);
        end
        alu_op   = c_alu_add;
        in_a     = 32'd100;
        in_b     = 32'd200;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== '0 || out_bcond !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b ready=%b result=%h bcond=%b required 1 0 0 1",
                         i, out_valid, in_ready, out_result, out_bcond);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] res;
        logic         bc;
        int           lat;
        alu_op   = c_alu_sll;
        in_a     = 32'd1;
        in_b     = 32'd20;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== '0) begin
            errors++;
            $display("FAIL reset_mid_shift: valid=%b ready=%b result=%h required 0 1 0",
                     out_valid, in_ready, out_result);
        end
        for (int i = 0; i < 25; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_discard_%0d: valid=%b required 0", i, out_valid);
            end
        end
        run_op(c_alu_add, 32'd2, 32'd3, 1'b1, res, bc, lat);
        checks++;
        if (res !== 32'd5 || bc !== 1'b0 || lat != 1) begin
            errors++;
            $display("FAIL add_after_reset: result=%h bcond=%b lat=%0d required 5 0 1", res, bc, lat);
        end
    endtask

    task automatic test_back_to_back();
        alu_op    = c_alu_xor;
        in_a      = 32'hF0F0_F0F0;
        in_b      = 32'h0FF0_0FF0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (out_valid !== (i % 2 == 0) || in_ready !== (i % 2 == 1) ||
                (out_valid && out_result !== 32'hFF00_FF00)) begin
                errors++;
                $display("FAIL back_to_back_%0d: valid=%b ready=%b result=%h required valid=%b ready=%b result=ff00ff00",
                         i, out_valid, in_ready, out_result, (i % 2 == 0), (i % 2 == 1));
            end
        end
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = '0;
        in_a      = '0;
        in_b      = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
